// File: rtl/mpx_coef_loader.sv
// mpx_coef_loader: stages FIR coefficients and replays them as one reload packet followed by a single config beat
// Ports: clk, reset (sync, active-high); coef_din/coef_wr/commit/clear are register-block strobes;
//   reload_tdata/tvalid/tlast/tready carry the coefficient packet; config_tvalid/config_tready the config beat;
//   count/busy/done/err report status back to the register block.
// Option: define MPX_COEF_RETAIN_EN to keep the staged set after a load so later commits replay it.
module mpx_coef_loader #(
  parameter int DEPTH = 64,
  parameter int COEF_W = 25
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COEF_W-1:0]      coef_din,
  input  logic                   coef_wr,
  input  logic                   commit,
  input  logic                   clear,
  output logic [31:0]            reload_tdata,
  output logic                   reload_tvalid,
  output logic                   reload_tlast,
  input  logic                   reload_tready,
  output logic                   config_tvalid,
  input  logic                   config_tready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef MPX_COEF_RETAIN_EN
  localparam bit RETAIN = 1'b1;
`else
  localparam bit RETAIN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RELOAD, CONFIG} state_t;
  state_t state, state_nx;
  logic [COEF_W-1:0] mem [DEPTH];
  logic [COEF_W-1:0] src;
  logic [CW-1:0] rd_idx, cnt_nx, idx_nx;
  logic idle, full, wr_ok, go, xfer, last_xfer, cfg_xfer, bad;
  assign busy = !idle;
  // A write staged in the same cycle as a commit joins the packet, so the load
  // uses cnt_nx and, for an empty buffer, takes entry 0 straight from coef_din.
  always_comb begin
    idle = state == IDLE;
    full = count == CW'(DEPTH);
    wr_ok = idle && coef_wr && !clear && !full;
    cnt_nx = count + CW'(wr_ok);
    go = idle && commit && !clear && cnt_nx != '0;
    xfer = state == RELOAD && reload_tvalid && reload_tready;
    last_xfer = xfer && reload_tlast;
    cfg_xfer = state == CONFIG && config_tready;
    bad = idle ? !clear && ((coef_wr && full) || (commit && cnt_nx == '0)) : coef_wr || commit || clear;
    idx_nx = go ? '0 : rd_idx + CW'(1);
    src = go && count == '0 ? coef_din : mem[idx_nx[AW-1:0]];
    state_nx = go ? RELOAD : last_xfer ? CONFIG : cfg_xfer ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (wr_ok) mem[count[AW-1:0]] <= coef_din;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      count <= '0;
      rd_idx <= '0;
      reload_tdata <= '0;
      reload_tvalid <= 1'b0;
      reload_tlast <= 1'b0;
      config_tvalid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      count <= (idle && clear) || (cfg_xfer && !RETAIN) ? '0 : cnt_nx;
      if (go || xfer) begin
        rd_idx <= idx_nx;
        reload_tdata <= 32'(signed'(src));
        reload_tlast <= idx_nx == cnt_nx - CW'(1);
      end
      reload_tvalid <= go || (reload_tvalid && !last_xfer);
      config_tvalid <= last_xfer || (config_tvalid && !cfg_xfer);
      done <= cfg_xfer;
      err <= bad;
    end
endmodule

// File: tb/tb_mpx_coef_loader.sv
// tb_mpx_coef_loader: directed stimulus with a queue-based packet model checked every cycle
module tb_mpx_coef_loader;
  localparam int DEPTH = 8;
  localparam int COEF_W = 25;
  logic clk = 1'b0, reset = 1'b1;
  logic [COEF_W-1:0] coef_din;
  logic coef_wr, commit, clear, reload_tready, config_tready;
  logic [31:0] reload_tdata;
  logic reload_tvalid, reload_tlast, config_tvalid, busy, done, err;
  logic [$clog2(DEPTH):0] count;
  typedef struct {logic [31:0] d; logic l;} beat_t;
  beat_t exp_q[$];
  beat_t b;
  logic [31:0] staged[$];
  logic stall_prev = 1'b0, prev_l = 1'b0;
  logic [31:0] prev_d = '0;
  int checks = 0, errors = 0, xfers = 0, cfgs = 0;
  mpx_coef_loader #(.DEPTH(DEPTH), .COEF_W(COEF_W)) dut (
    .clk(clk), .reset(reset), .coef_din(coef_din), .coef_wr(coef_wr), .commit(commit), .clear(clear),
    .reload_tdata(reload_tdata), .reload_tvalid(reload_tvalid), .reload_tlast(reload_tlast),
    .reload_tready(reload_tready), .config_tvalid(config_tvalid), .config_tready(config_tready),
    .count(count), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] sx(input logic [COEF_W-1:0] v);
    return v[COEF_W-1] ? 32'(v) - (32'd1 << COEF_W) : 32'(v);
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic stage(input logic [COEF_W-1:0] v);
    coef_din = v;
    coef_wr = 1'b1;
    cyc();
    coef_wr = 1'b0;
    if (staged.size() < DEPTH) staged.push_back(sx(v));
  endtask
  task automatic model_commit();
    foreach (staged[i]) exp_q.push_back('{staged[i], i == staged.size() - 1});
`ifndef MPX_COEF_RETAIN_EN
    staged.delete();
`endif
  endtask
  task automatic do_commit();
    model_commit();
    commit = 1'b1;
    cyc();
    commit = 1'b0;
  endtask
  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    staged.delete();
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      cyc();
      n++;
    end
    check(name, done, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_count"}, count, staged.size());
    cyc();
    check({name, "_pulse"}, done, 0);
  endtask
  always @(negedge clk)
    if (reset) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        check("hold_valid", reload_tvalid, 1);
        check("hold_data", reload_tdata, prev_d);
        check("hold_last", reload_tlast, prev_l);
      end
      check("one_valid", reload_tvalid && config_tvalid, 0);
      if (reload_tvalid && reload_tready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("beat_data", reload_tdata, b.d);
          check("beat_last", reload_tlast, b.l);
        end
        xfers++;
      end
      if (config_tvalid && config_tready) begin
        check("cfg_after_packet", exp_q.size(), 0);
        cfgs++;
      end
      stall_prev = reload_tvalid && !reload_tready;
      prev_d = reload_tdata;
      prev_l = reload_tlast;
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, x0, c0;
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    logic [31:0] expd[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00ABCDEF, 32'h00ABCDEF};
    {coef_din, coef_wr, commit, clear, reload_tready, config_tready} = '0;
    repeat (3) cyc();
    check("rst_tdata", reload_tdata, 0);
    check("rst_tvalid", reload_tvalid, 0);
    check("rst_tlast", reload_tlast, 0);
    check("rst_cfg", config_tvalid, 0);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    cyc();
    stage(25'h0000001); stage(25'h1FFFFFF); stage(25'h0ABCDEF);
    check("t1_count", count, 3);
    reload_tready = 1'b1;
    config_tready = 1'b1;
    do_commit();
    check("t1_busy", busy, 1);
    check("t1_d0", reload_tdata, 32'h00000001);
    check("t1_l0", reload_tlast, 0);
    cyc();
    check("t1_d1", reload_tdata, 32'hFFFFFFFF);
    check("t1_l1", reload_tlast, 0);
    cyc();
    check("t1_d2", reload_tdata, 32'h00ABCDEF);
    check("t1_l2", reload_tlast, 1);
    cyc();
    check("t1_cfg", config_tvalid, 1);
    check("t1_rvalid", reload_tvalid, 0);
    cyc();
    check("t1_done", done, 1);
    check("t1_cfg_low", config_tvalid, 0);
    check("t1_count_after", count, staged.size());
    cyc();
    check("t1_done_pulse", done, 0);
    do_clear();
    stage(25'h0000001); stage(25'h1FFFFFF); stage(25'h0ABCDEF);
    reload_tready = 1'b0;
    do_commit();
    x0 = xfers;
    check("t2_d0", reload_tdata, 32'h00000001);
    foreach (pat[i]) begin
      reload_tready = pat[i][0];
      cyc();
      if (i < 5) check("t2_data", reload_tdata, expd[i]);
    end
    check("t2_cfg", config_tvalid, 1);
    check("t2_xfers", xfers - x0, 3);
    reload_tready = 1'b1;
    wait_done("t2_done");
    do_clear();
    commit = 1'b1;
    cyc();
    commit = 1'b0;
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    check("t3_valid", reload_tvalid, 0);
    cyc();
    check("t3_err_pulse", err, 0);
    check("t3_valid2", reload_tvalid, 0);
    for (int i = 0; i < DEPTH; i++) stage(COEF_W'(i * 32'h00345677) ^ (i[0] ? 25'h1000000 : 25'h0));
    check("t4_count_full", count, DEPTH);
    check("t4_no_err", err, 0);
    stage(25'h0000005);
    check("t4_err", err, 1);
    check("t4_count_kept", count, DEPTH);
    x0 = xfers;
    do_commit();
    wait_done("t4_done");
    check("t4_xfers", xfers - x0, DEPTH);
    do_clear();
    stage(25'h0123456); stage(25'h1800000);
    reload_tready = 1'b0;
    config_tready = 1'b0;
    do_commit();
    coef_din = 25'h0000777;
    coef_wr = 1'b1;
    cyc();
    coef_wr = 1'b0;
    check("t5_wr_err", err, 1);
    check("t5_count_frozen", count, 2);
    commit = 1'b1;
    cyc();
    commit = 1'b0;
    check("t5_commit_err", err, 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("t5_clear_err", err, 1);
    check("t5_count_frozen2", count, 2);
    cyc();
    check("t5_err_low", err, 0);
    reload_tready = 1'b1;
    c0 = cfgs;
    n = 0;
    while (!config_tvalid && n < 50) begin
      cyc();
      n++;
    end
    check("t5_cfg_up", config_tvalid, 1);
    for (int i = 0; i < 5; i++) begin
      check("t5_cfg_held", config_tvalid, 1);
      check("t5_no_done", done, 0);
      cyc();
    end
    config_tready = 1'b1;
    cyc();
    check("t5_cfg_low", config_tvalid, 0);
    check("t5_done", done, 1);
    check("t5_cfgs", cfgs - c0, 1);
    cyc();
    check("t5_done_pulse", done, 0);
    do_clear();
    stage(25'h0000011); stage(25'h0000022);
    coef_wr = 1'b1;
    clear = 1'b1;
    commit = 1'b1;
    staged.delete();
    cyc();
    {coef_wr, clear, commit} = '0;
    check("t6_clear_count", count, 0);
    check("t6_clear_err", err, 0);
    check("t6_clear_busy", busy, 0);
    coef_din = 25'h1555555;
    coef_wr = 1'b1;
    staged.push_back(sx(25'h1555555));
    do_commit();
    coef_wr = 1'b0;
    check("t6_wc_err", err, 0);
    check("t6_wc_busy", busy, 1);
    check("t6_wc_data", reload_tdata, 32'hFF555555);
    check("t6_wc_last", reload_tlast, 1);
    wait_done("t6_done");
`ifdef MPX_COEF_RETAIN_EN
    do_clear();
    stage(25'h0000042); stage(25'h1FFFF00);
    x0 = xfers;
    do_commit();
    wait_done("r_done1");
    check("r_count1", count, 2);
    do_commit();
    wait_done("r_done2");
    check("r_count2", count, 2);
    check("r_xfers", xfers - x0, 4);
`endif
    do_clear();
    stage(25'h0000003); stage(25'h0000004); stage(25'h0000005);
    do_commit();
    cyc();
    reset = 1'b1;
    exp_q.delete();
    staged.delete();
    cyc();
    check("t7_rvalid", reload_tvalid, 0);
    check("t7_cfg", config_tvalid, 0);
    check("t7_busy", busy, 0);
    check("t7_count", count, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t7_no_done", done, 0);
      check("t7_no_valid", reload_tvalid, 0);
    end
    check("leftover_beats", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
